// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline slice: forward-select codes,
// trap FSM encoding and default register-address width.
package mips_pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_EXMEM = 2'b11;

  typedef enum logic {
    NORMAL = 1'b0,
    TRAP   = 1'b1
  } trap_state_e;

endpackage

// File: rtl/ex_mem_stage_fwd_select.sv
// Operand-forward select for one ALU source: EX/MEM wins over MEM/WB,
// and register 0 is never forwarded.
module fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exmem_dest,
  input  logic              exmem_fwd,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (exmem_fwd && (exmem_dest == src)) begin
        sel = FWD_EXMEM;
      end else if (wb_reg_write && (wb_dest == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with forwarding selects, load-use detect and
// branch resolve. Overflow trap FSM is built only when OVF_TRAP_EN is defined.
module ex_mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_branch_target,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch_eq,
  input  logic              ex_branch_ne,
  input  logic              ex_ovf_trap,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              stall,
  input  logic              flush,
  input  logic              exc_ack,
  output logic [DATA_W-1:0] alu_op_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic [REG_AW-1:0] dest_q,
  output logic              reg_write_q,
  output logic              mem_read_q,
  output logic              mem_write_q,
  output logic              valid_q,
  output logic              branch_taken_q,
  output logic [31:0]       branch_target_q,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              load_use_stall,
  output logic              exc_pending,
  output logic [31:0]       epc_q
);

  logic              advance;
  logic              stall_hold;
  logic              in_trap;
  logic              trap_take;
  logic              take;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_reg_write;
  logic              exmem_fwd;

  assign advance    = ~stall & ~flush;
  assign stall_hold = stall & ~flush;

`ifdef OVF_TRAP_EN
  // state  | meaning
  // NORMAL | instructions commit normally
  // TRAP   | overflow trap raised; all incoming instructions squashed until exc_ack
  trap_state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (advance && ex_valid && ex_ovf_trap && alu_overflow) state_d = TRAP;
      TRAP:    if (exc_ack) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    in_trap     = (state_q == TRAP);
    trap_take   = (state_q == NORMAL) && (state_d == TRAP);
    exc_pending = in_trap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          epc_q <= '0;
    else if (trap_take) epc_q <= ex_pc;
  end
`else
  logic unused_trap_inputs;

  assign in_trap            = 1'b0;
  assign trap_take          = 1'b0;
  assign exc_pending        = 1'b0;
  assign epc_q              = '0;
  assign unused_trap_inputs = ^{exc_ack, alu_overflow, ex_ovf_trap, ex_pc};
`endif

  assign take = ex_valid & ~in_trap & ~trap_take;

  // branch_taken_q is a one-cycle pulse, so it drops while the slot is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_q        <= '0;
      store_data_q    <= '0;
      dest_q          <= '0;
      branch_target_q <= '0;
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
    end else if (flush) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      branch_taken_q <= 1'b0;
    end else if (stall) begin
      branch_taken_q <= 1'b0;
    end else begin
      alu_op_q        <= alu_result;
      store_data_q    <= ex_store_data;
      dest_q          <= ex_dest;
      branch_target_q <= ex_branch_target;
      valid_q         <= take;
      reg_write_q     <= take & ex_reg_write;
      mem_read_q      <= take & ex_mem_read;
      mem_write_q     <= take & ex_mem_write;
      branch_taken_q  <= take & ((ex_branch_eq & alu_zero) | (ex_branch_ne & ~alu_zero));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_dest      <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_dest      <= dest_q;
      wb_reg_write <= valid_q & reg_write_q & ~stall_hold;
    end
  end

  assign exmem_fwd = valid_q & reg_write_q & ~mem_read_q;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (id_rs),
    .exmem_dest   (dest_q),
    .exmem_fwd    (exmem_fwd),
    .wb_dest      (wb_dest),
    .wb_reg_write (wb_reg_write),
    .sel          (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (id_rt),
    .exmem_dest   (dest_q),
    .exmem_fwd    (exmem_fwd),
    .wb_dest      (wb_dest),
    .wb_reg_write (wb_reg_write),
    .sel          (sel_b)
  );

  assign load_use_stall = valid_q & mem_read_q & (dest_q != '0) &
                          ((dest_q == id_rs) | (dest_q == id_rt));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// run against a behavioural model. Trap expectations follow OVF_TRAP_EN.
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_overflow;
  logic [DATA_W-1:0] ex_store_data;
  logic [31:0]       ex_pc, ex_branch_target;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              ex_branch_eq, ex_branch_ne, ex_ovf_trap;
  logic [REG_AW-1:0] ex_dest, id_rs, id_rt;
  logic              stall, flush, exc_ack;
  logic [DATA_W-1:0] alu_op_q, store_data_q;
  logic [REG_AW-1:0] dest_q;
  logic              reg_write_q, mem_read_q, mem_write_q, valid_q, branch_taken_q;
  logic [31:0]       branch_target_q, epc_q;
  logic [1:0]        sel_a, sel_b;
  logic              load_use_stall, exc_pending;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_branch_target(ex_branch_target),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_ovf_trap(ex_ovf_trap), .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt),
    .stall(stall), .flush(flush), .exc_ack(exc_ack),
    .alu_op_q(alu_op_q), .store_data_q(store_data_q), .dest_q(dest_q),
    .reg_write_q(reg_write_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
    .valid_q(valid_q), .branch_taken_q(branch_taken_q), .branch_target_q(branch_target_q),
    .sel_a(sel_a), .sel_b(sel_b), .load_use_stall(load_use_stall),
    .exc_pending(exc_pending), .epc_q(epc_q)
  );

  always #5 clk = ~clk;

  // Behavioural view: what instruction sits in EX/MEM, what sits in MEM/WB, trap status.
  typedef struct {
    logic              valid, rw, mr, mw, bt;
    logic [DATA_W-1:0] alu, sd;
    logic [REG_AW-1:0] dest;
    logic [31:0]       tgt;
  } slot_t;

  slot_t             m_slot;
  logic [REG_AW-1:0] m_wb_dest;
  logic              m_wb_rw;
  logic              m_trap;
  logic [31:0]       m_epc;

  task automatic model_reset();
    m_slot    = '{valid: 0, rw: 0, mr: 0, mw: 0, bt: 0, alu: 0, sd: 0, dest: 0, tgt: 0};
    m_wb_dest = '0;
    m_wb_rw   = 1'b0;
    m_trap    = 1'b0;
    m_epc     = '0;
  endtask

  function automatic logic [1:0] exp_sel(input logic [REG_AW-1:0] s);
    if (s == 0) return 2'b00;
    if (m_slot.valid && m_slot.rw && !m_slot.mr && m_slot.dest == s) return 2'b11;
    if (m_wb_rw && m_wb_dest == s) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    slot_t             n_slot;
    logic              trapping, n_trap, keep;
    logic [31:0]       n_epc;
    logic [REG_AW-1:0] n_wb_dest;
    logic              n_wb_rw;
    n_slot = m_slot;
    n_trap = m_trap;
    n_epc  = m_epc;
`ifdef OVF_TRAP_EN
    trapping = !stall && !flush && !m_trap && ex_valid && ex_ovf_trap && alu_overflow;
    if (m_trap && exc_ack) n_trap = 1'b0;
    if (trapping) begin
      n_trap = 1'b1;
      n_epc  = ex_pc;
    end
`else
    trapping = 1'b0;
`endif
    keep = ex_valid && !m_trap && !trapping;
    // The instruction leaving EX/MEM retires into MEM/WB unless it is being held.
    n_wb_dest = m_slot.dest;
    n_wb_rw   = m_slot.valid && m_slot.rw && !(stall && !flush);
    if (flush) begin
      n_slot.valid = 0; n_slot.rw = 0; n_slot.mr = 0; n_slot.mw = 0; n_slot.bt = 0;
    end else if (stall) begin
      n_slot.bt = 0;
    end else begin
      n_slot.valid = keep;
      n_slot.rw    = keep && ex_reg_write;
      n_slot.mr    = keep && ex_mem_read;
      n_slot.mw    = keep && ex_mem_write;
      n_slot.bt    = keep && (alu_zero ? ex_branch_eq : ex_branch_ne);
      n_slot.alu   = alu_result;
      n_slot.sd    = ex_store_data;
      n_slot.dest  = ex_dest;
      n_slot.tgt   = ex_branch_target;
    end
    @(posedge clk);
    #1;
    m_slot    = n_slot;
    m_wb_dest = n_wb_dest;
    m_wb_rw   = n_wb_rw;
    m_trap    = n_trap;
    m_epc     = n_epc;
  endtask

  task automatic idle();
    alu_result = '0; alu_zero = 0; alu_overflow = 0; ex_store_data = '0;
    ex_pc = '0; ex_branch_target = '0; ex_valid = 0; ex_reg_write = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_branch_eq = 0; ex_branch_ne = 0;
    ex_ovf_trap = 0; ex_dest = '0; id_rs = '0; id_rt = '0;
    stall = 0; flush = 0; exc_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_reset();
    #12;
    n_checks++;
    if ({valid_q, reg_write_q, mem_read_q, mem_write_q, branch_taken_q} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {valid_q, reg_write_q, mem_read_q, mem_write_q, branch_taken_q});
    end
    n_checks++;
    if ({alu_op_q, store_data_q, dest_q, branch_target_q} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: alu=%h sd=%h dest=%0d tgt=%h", alu_op_q, store_data_q, dest_q, branch_target_q);
    end
    n_checks++;
    if ({exc_pending, epc_q, sel_a, sel_b, load_use_stall} !== '0) begin
      n_errors++;
      $display("FAIL reset_misc: exc=%b epc=%h sel_a=%b sel_b=%b lus=%b",
               exc_pending, epc_q, sel_a, sel_b, load_use_stall);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_forward();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd8; alu_result = 32'h0000_0010;
    tick();
    idle();
    id_rs = 5'd8;
    #1;
    n_checks++;
    if (alu_op_q !== 32'h10) begin
      n_errors++; $display("FAIL fwd_alu_op: got %h want 00000010", alu_op_q);
    end
    n_checks++;
    if (sel_a !== 2'b11) begin
      n_errors++; $display("FAIL fwd_exmem: sel_a got %b want 11", sel_a);
    end
    tick();
    n_checks++;
    if (sel_a !== 2'b10) begin
      n_errors++; $display("FAIL fwd_memwb: sel_a got %b want 10", sel_a);
    end
    tick();
    n_checks++;
    if (sel_a !== 2'b00) begin
      n_errors++; $display("FAIL fwd_rf: sel_a got %b want 00", sel_a);
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 5'd9;
    tick();
    idle();
    id_rt = 5'd9;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b1) begin
      n_errors++; $display("FAIL load_use: stall got %b want 1", load_use_stall);
    end
    n_checks++;
    if (sel_b !== 2'b00) begin
      n_errors++; $display("FAIL load_no_fwd: sel_b got %b want 00", sel_b);
    end
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 5'd0; id_rt = 5'd0;
    tick();
    idle();
    #1;
    n_checks++;
    if ({sel_a, load_use_stall} !== 3'b000) begin
      n_errors++; $display("FAIL reg0: sel_a=%b lus=%b want 00 0", sel_a, load_use_stall);
    end
  endtask

  task automatic test_branch();
    idle();
    ex_valid = 1; ex_branch_eq = 1; alu_zero = 1; ex_branch_target = 32'h0040_0020;
    tick();
    idle();
    n_checks++;
    if ({branch_taken_q, branch_target_q} !== {1'b1, 32'h0040_0020}) begin
      n_errors++; $display("FAIL beq_taken: got %b %h want 1 00400020", branch_taken_q, branch_target_q);
    end
    tick();
    n_checks++;
    if (branch_taken_q !== 1'b0) begin
      n_errors++; $display("FAIL beq_pulse: got %b want 0", branch_taken_q);
    end
    ex_valid = 1; ex_branch_ne = 1; alu_zero = 1;
    tick();
    idle();
    n_checks++;
    if (branch_taken_q !== 1'b0) begin
      n_errors++; $display("FAIL bne_not_taken: got %b want 0", branch_taken_q);
    end
  endtask

  task automatic test_stall();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd5;
    alu_result = 32'hA5A5_0001; ex_store_data = 32'h1234_5678;
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      alu_result = $urandom; ex_store_data = $urandom; ex_dest = 5'($urandom);
      ex_valid = 1'($urandom); ex_mem_write = 1'($urandom);
      ex_ovf_trap = 1; alu_overflow = 1;
      tick();
      n_checks++;
      if ({alu_op_q, store_data_q, dest_q, valid_q, reg_write_q, mem_write_q}
          !== {32'hA5A5_0001, 32'h1234_5678, 5'd5, 1'b1, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: alu=%h sd=%h dest=%0d v=%b rw=%b mw=%b", i,
                 alu_op_q, store_data_q, dest_q, valid_q, reg_write_q, mem_write_q);
      end
      n_checks++;
      if (exc_pending !== 1'b0) begin
        n_errors++; $display("FAIL stall_no_ovf[%0d]: exc got %b want 0", i, exc_pending);
      end
    end
    stall = 1; flush = 1;
    tick();
    n_checks++;
    if ({valid_q, reg_write_q} !== 2'b00) begin
      n_errors++; $display("FAIL stall_flush: v=%b rw=%b want 0 0", valid_q, reg_write_q);
    end
    idle();
  endtask

  task automatic test_trap();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_ovf_trap = 1; alu_overflow = 1;
    ex_dest = 5'd3; alu_result = 32'h8000_0000; ex_pc = 32'h0040_0100;
    tick();
    idle();
`ifdef OVF_TRAP_EN
    n_checks++;
    if ({exc_pending, epc_q, reg_write_q, valid_q} !== {1'b1, 32'h0040_0100, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL trap_enter: exc=%b epc=%h rw=%b v=%b", exc_pending, epc_q, reg_write_q, valid_q);
    end
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd4; ex_pc = 32'h0040_0104;
      tick();
      n_checks++;
      if ({valid_q, reg_write_q, exc_pending} !== 3'b001) begin
        n_errors++; $display("FAIL trap_squash[%0d]: v=%b rw=%b exc=%b", i, valid_q, reg_write_q, exc_pending);
      end
    end
    idle();
    exc_ack = 1;
    tick();
    exc_ack = 0;
    n_checks++;
    if ({exc_pending, epc_q} !== {1'b0, 32'h0040_0100}) begin
      n_errors++; $display("FAIL trap_ack: exc=%b epc=%h want 0 00400100", exc_pending, epc_q);
    end
    ex_valid = 1; ex_reg_write = 1; ex_ovf_trap = 1; alu_overflow = 1; flush = 1;
    tick();
    idle();
    n_checks++;
    if ({exc_pending, valid_q} !== 2'b00) begin
      n_errors++; $display("FAIL ovf_flush: exc=%b v=%b want 0 0", exc_pending, valid_q);
    end
`else
    n_checks++;
    if ({reg_write_q, valid_q, exc_pending, epc_q} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      n_errors++; $display("FAIL ovf_commit: rw=%b v=%b exc=%b epc=%h", reg_write_q, valid_q, exc_pending, epc_q);
    end
`endif
  endtask

  task automatic test_reset_mid();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_ovf_trap = 1; alu_overflow = 1;
    ex_dest = 5'd7; alu_result = 32'hDEAD_BEEF; ex_pc = 32'h0040_0200;
    tick();
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd7; id_rs = 5'd7;
    tick();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({exc_pending, epc_q, valid_q, reg_write_q, alu_op_q, dest_q, sel_a} !== '0) begin
      n_errors++; $display("FAIL async_reset: exc=%b epc=%h v=%b rw=%b alu=%h sel_a=%b",
                           exc_pending, epc_q, valid_q, reg_write_q, alu_op_q, sel_a);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd2;
    tick();
    idle();
    n_checks++;
    if ({valid_q, reg_write_q, exc_pending} !== 3'b110) begin
      n_errors++; $display("FAIL post_reset: v=%b rw=%b exc=%b want 1 1 0", valid_q, reg_write_q, exc_pending);
    end
  endtask

  task automatic test_random();
    logic [1:0] e_a, e_b;
    logic       e_lus;
    for (int i = 0; i < 600; i++) begin
      alu_result = $urandom; alu_zero = ($urandom_range(0, 1) == 1);
      ex_store_data = $urandom; ex_pc = $urandom; ex_branch_target = $urandom;
      ex_valid = ($urandom_range(0, 4) != 0);
      ex_reg_write = 1'($urandom); ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_mem_write = ($urandom_range(0, 3) == 0);
      ex_branch_eq = ($urandom_range(0, 3) == 0); ex_branch_ne = ($urandom_range(0, 3) == 0);
      ex_ovf_trap = 1'($urandom); alu_overflow = ($urandom_range(0, 7) == 0);
      ex_dest = 5'($urandom_range(0, 6)); id_rs = 5'($urandom_range(0, 6)); id_rt = 5'($urandom_range(0, 6));
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 9) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      #1;
      e_a   = exp_sel(id_rs);
      e_b   = exp_sel(id_rt);
      e_lus = m_slot.valid && m_slot.mr && m_slot.dest != 0 && (m_slot.dest == id_rs || m_slot.dest == id_rt);
      n_checks++;
      if ({sel_a, sel_b, load_use_stall} !== {e_a, e_b, e_lus}) begin
        n_errors++; $display("FAIL rnd_comb[%0d]: sel_a=%b sel_b=%b lus=%b want %b %b %b",
                             i, sel_a, sel_b, load_use_stall, e_a, e_b, e_lus);
      end
      tick();
      n_checks++;
      if ({valid_q, reg_write_q, mem_read_q, mem_write_q, branch_taken_q, exc_pending}
          !== {m_slot.valid, m_slot.rw, m_slot.mr, m_slot.mw, m_slot.bt, m_trap}) begin
        n_errors++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
          {valid_q, reg_write_q, mem_read_q, mem_write_q, branch_taken_q, exc_pending},
          {m_slot.valid, m_slot.rw, m_slot.mr, m_slot.mw, m_slot.bt, m_trap});
      end
      n_checks++;
      if ({alu_op_q, store_data_q, dest_q, branch_target_q, epc_q}
          !== {m_slot.alu, m_slot.sd, m_slot.dest, m_slot.tgt, m_epc}) begin
        n_errors++; $display("FAIL rnd_data[%0d]: alu=%h sd=%h dest=%0d tgt=%h epc=%h want %h %h %0d %h %h", i,
          alu_op_q, store_data_q, dest_q, branch_target_q, epc_q,
          m_slot.alu, m_slot.sd, m_slot.dest, m_slot.tgt, m_epc);
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_stall();
    test_trap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the ALU. Captures the ALU result, flags and control bits each cycle.
- Drives `alu_op_q` back into the ALU as a forwarding source.
- Tracks the MEM/WB destination register internally and generates the ALU operand-forward selects `sel_a`/`sel_b`.
- Resolves branches and handles arithmetic-overflow traps with a small FSM.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- alu_result  in  DATA_W  ALU Output.
- alu_zero  in  1  ALU Zero.
- alu_overflow  in  1  ALU Overflow.
- ex_store_data  in  DATA_W  forwarded rt value for stores.
- ex_pc  in  32  PC of the EX instruction.
- ex_branch_target  in  32  computed branch target.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
- ex_branch_eq, ex_branch_ne  in  1 each  beq/bne.
- ex_ovf_trap  in  1  EX instruction is signed add/sub/addi.
- ex_dest  in  REG_AW  destination register.
- id_rs, id_rt  in  REG_AW  sources of the instruction entering EX next cycle.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  insert a bubble.
- exc_ack  in  1  exception handler acknowledge.
- alu_op_q  out  DATA_W  registered ALU result.
- store_data_q  out  DATA_W  registered store data.
- dest_q  out  REG_AW  EX/MEM destination.
- reg_write_q, mem_read_q, mem_write_q, valid_q  out  1 each  EX/MEM control.
- branch_taken_q  out  1  registered branch decision.
- branch_target_q  out  32  registered branch target.
- sel_a, sel_b  out  2  forward selects to the ALU.
- load_use_stall  out  1  stall request.
- exc_pending  out  1  trap in progress.
- epc_q  out  32  PC of the trapping instruction.

Behaviour:
- Reset (async, active-high): every registered output is 0, including the MEM/WB tracking registers; FSM goes to NORMAL.
- Latency: 1 cycle, EX inputs to `*_q` outputs.
- Advance (no stall, no flush): all `*_q` outputs load from the EX inputs. The MEM/WB tracker (`wb_dest`, `wb_reg_write`) loads from `dest_q`/`reg_write_q` AND `valid_q`.
- Stall = 1, flush = 0: EX/MEM registers hold their values. The MEM/WB tracker still advances and loads a bubble (`wb_reg_write` = 0).
- Flush = 1: the EX/MEM slot becomes a bubble: `valid_q`, `reg_write_q`, `mem_read_q`, `mem_write_q`, `branch_taken_q` all 0; the data registers may hold. Flush has priority over stall.
- Squash (`ex_valid` = 0 or FSM in TRAP): captured as a bubble.
- Branch: `branch_taken_q` = `ex_valid` & ((`ex_branch_eq` & `alu_zero`) | (`ex_branch_ne` & ~`alu_zero`)). It is high for exactly one cycle per taken branch.
- Forward selects (combinational from registered state). For each source s in {`id_rs`→`sel_a`, `id_rt`→`sel_b`}:
  - 2'b11 if `valid_q` & `reg_write_q` & ~`mem_read_q` & `dest_q` == s & s != 0.
  - else 2'b10 if `wb_reg_write` & `wb_dest` == s & s != 0.
  - else 2'b00.
  - EX/MEM beats MEM/WB. Register 0 is never forwarded.
- `load_use_stall` = `valid_q` & `mem_read_q` & `dest_q` != 0 & (`dest_q` == `id_rs` | `dest_q` == `id_rt`). It is a combinational request; the upstream hazard unit converts it to a stall plus bubble.
- Trap FSM, states NORMAL and TRAP:
  - NORMAL→TRAP when advancing, `ex_valid` & `ex_ovf_trap` & `alu_overflow`. That instruction is squashed (captured as a bubble), `epc_q` <= `ex_pc`, `exc_pending` <= 1.
  - While stalled, overflow is not sampled.
  - In TRAP, every incoming instruction is squashed. `exc_ack` moves the FSM TRAP→NORMAL and clears `exc_pending` next cycle; `epc_q` holds its value.
  - `exc_ack` in NORMAL is ignored. Overflow together with `flush` means no trap.
- Reset during TRAP: returns to NORMAL, `epc_q` = 0.

Optional Feature:
- Macro `OVF_TRAP_EN`.
- Defined: trap FSM, `epc_q` and `exc_pending` exist as described.
- Undefined: overflow is ignored, the overflowing instruction commits normally, `exc_pending` and `epc_q` are tied to 0, `exc_ack` is unused, and no FSM state register is built.

Decomposition:
- Package `mips_pipe_pkg` holds:
  - forward-select constants: FWD_RF = 2'b00, FWD_MEMWB = 2'b10, FWD_EXMEM = 2'b11;
  - trap FSM state encoding: NORMAL = 1'b0, TRAP = 1'b1;
  - the REG_AW default.
- One sub-module, `fwd_select`: a combinational compare of one source register against the EX/MEM and MEM/WB destinations that outputs a 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- `add` with `ex_dest`=8, `alu_result`=0x0000_0010, advance; next cycle `id_rs`=8 → `alu_op_q`=0x10, `sel_a`=2'b11. One cycle later (bubble in EX) → `sel_a`=2'b10. Then 2'b00.
- `lw` with `ex_dest`=9, `ex_mem_read`=1; next cycle `id_rt`=9 → `load_use_stall`=1, `sel_b`=2'b00. Destination 0 with `id_rs`=0 → `sel_a`=2'b00, no stall.
- `beq` with `alu_zero`=1, target 0x0040_0020 → `branch_taken_q`=1 for one cycle, `branch_target_q`=0x0040_0020. `bne` with `alu_zero`=1 → 0.
- `stall`=1 for 3 cycles with changing EX inputs → `*_q` outputs unchanged. `stall`=`flush`=1 → `valid_q`=0, `reg_write_q`=0.
- With `OVF_TRAP_EN` defined: `add` 0x7FFF_FFFF+1 at `ex_pc`=0x0040_0100 with `alu_overflow`=1 → `exc_pending`=1, `epc_q`=0x0040_0100, `reg_write_q`=0, following instructions squashed; `exc_ack` → `exc_pending`=0 next cycle. Without the macro → `reg_write_q`=1, `exc_pending`=0.
- Assert `reset` asynchronously mid-TRAP → all outputs 0 immediately, FSM in NORMAL after release.
